// File: rtl/trng_bitpool.sv
// trng_bitpool: repetition-count health test, optional von Neumann debias and bit pool.
// Define TRNG_VN_DEBIAS_EN to enable the von Neumann corrector.
module trng_bitpool #(
  parameter int DEPTH      = 32,
  parameter int RCT_CUTOFF = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       raw_bit,
  input  logic                       raw_valid,
  input  logic                       trng_req,
  output logic                       trng_bit,
  output logic [$clog2(DEPTH+1)-1:0] pool_count,
  output logic                       pool_empty,
  output logic                       health_fail,
  output logic                       underrun
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] CUT = 8'(RCT_CUTOFF);

  logic [DEPTH-1:0] pool;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [7:0]       run_len;
  logic [7:0]       run_nxt;
  logic             last_bit;
  logic             trip;
  logic             fail_nxt;
  logic             pop;
  logic             push_ok;
  logic             push_bit;
  logic             push;

  always_comb begin
    run_nxt = run_len;
    if (raw_valid) begin
      if (run_len == 8'd0 || raw_bit != last_bit)
        run_nxt = 8'd1;
      else if (run_len != 8'hff)
        run_nxt = run_len + 8'd1;
    end
  end

  assign trip     = raw_valid && (run_nxt == CUT);
  assign fail_nxt = health_fail || trip;

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_bit;
  logic have_first;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pair_bit   <= 1'b0;
      have_first <= 1'b0;
    end else if (raw_valid) begin
      have_first <= !have_first;
      if (!have_first)
        pair_bit <= raw_bit;
    end
  end

  assign push_ok  = raw_valid && have_first && (pair_bit != raw_bit);
  assign push_bit = pair_bit;
`else
  assign push_ok  = raw_valid;
  assign push_bit = raw_bit;
`endif

  assign pool_empty = (pool_count == '0);
  assign pop  = trng_req && !pool_empty && !health_fail;
  // a simultaneous pop frees the slot a full-pool push needs
  assign push = push_ok && !fail_nxt && (pool_count != FULL || pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pool        <= '0;
      head        <= '0;
      tail        <= '0;
      pool_count  <= '0;
      run_len     <= 8'd0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (raw_valid) begin
        run_len  <= run_nxt;
        last_bit <= raw_bit;
      end
      if (trip)
        health_fail <= 1'b1;
      if (trng_req && pool_empty)
        underrun <= 1'b1;
      if (fail_nxt) begin
        head       <= '0;
        tail       <= '0;
        pool_count <= '0;
      end else begin
        if (push) begin
          pool[tail] <= push_bit;
          tail       <= tail + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        case ({push, pop})
          2'b10:   pool_count <= pool_count + CW'(1);
          2'b01:   pool_count <= pool_count - CW'(1);
          default: pool_count <= pool_count;
        endcase
      end
    end
  end

  assign trng_bit = pool[head] && !pool_empty && !health_fail;

endmodule

// File: tb/tb_trng_bitpool.sv
// tb_trng_bitpool: randomized and directed checks of trng_bitpool
// against a queue-based reference model.
module tb_trng_bitpool;

  localparam int DEPTH = 32;
  localparam int CUT   = 8;
`ifdef TRNG_VN_DEBIAS_EN
  localparam bit VN = 1'b1;
`else
  localparam bit VN = 1'b0;
`endif
  localparam int BPB = VN ? 2 : 1;

  logic       clk;
  logic       resetn;
  logic       raw_bit;
  logic       raw_valid;
  logic       trng_req;
  logic       trng_bit;
  logic [5:0] pool_count;
  logic       pool_empty;
  logic       health_fail;
  logic       underrun;

  trng_bitpool #(
    .DEPTH      (DEPTH),
    .RCT_CUTOFF (CUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .trng_req    (trng_req),
    .trng_bit    (trng_bit),
    .pool_count  (pool_count),
    .pool_empty  (pool_empty),
    .health_fail (health_fail),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit q[$];
  int m_run;
  bit m_last;
  bit m_have;
  bit m_first;
  bit m_hf;
  bit m_ur;
  int n_vec;
  int n_bad;
  bit t1e [3] = '{1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run   = 0;
    m_last  = 1'b0;
    m_have  = 1'b0;
    m_first = 1'b0;
    m_hf    = 1'b0;
    m_ur    = 1'b0;
  endtask

  task automatic model_step(input bit rv, input bit rb, input bit req);
    bit pop;
    bit do_push;
    bit pb;
    pop     = req && q.size() > 0 && !m_hf;
    do_push = 1'b0;
    pb      = 1'b0;
    if (req && q.size() == 0) m_ur = 1'b1;
    if (rv) begin
      if (m_run == 0 || rb != m_last) m_run = 1;
      else if (m_run < 255) m_run++;
      m_last = rb;
      if (m_run == CUT) m_hf = 1'b1;
      if (VN) begin
        if (!m_have) begin
          m_first = rb;
          m_have  = 1'b1;
        end else begin
          m_have = 1'b0;
          if (m_first != rb) begin
            do_push = 1'b1;
            pb      = m_first;
          end
        end
      end else begin
        do_push = 1'b1;
        pb      = rb;
      end
    end
    if (pop) void'(q.pop_front());
    if (m_hf) q.delete();
    else if (do_push && q.size() < DEPTH) q.push_back(pb);
  endtask

  task automatic check_all();
    bit eb;
    eb = (q.size() > 0 && !m_hf) ? q[0] : 1'b0;
    chk("trng_bit", 32'(trng_bit), 32'(eb));
    chk("pool_count", 32'(pool_count), 32'(q.size()));
    chk("pool_empty", 32'(pool_empty), 32'(q.size() == 0));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    chk("underrun", 32'(underrun), 32'(m_ur));
  endtask

  task automatic cyc(input bit rv, input bit rb, input bit req);
    raw_valid = rv;
    raw_bit   = rb;
    trng_req  = req;
    model_step(rv, rb, req);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    raw_valid = 1'b0;
    trng_req  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_count", 32'(pool_count), 32'd0);
    chk("rst_bit", 32'(trng_bit), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    check_all();
  endtask

  function automatic bit gen_rb();
    if (m_run >= CUT - 1) return !m_last;
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    bit rv;
    bit rb;
    bit req;
    int reqp;
    n_vec     = 0;
    n_bad     = 0;
    resetn    = 1'b0;
    raw_valid = 1'b0;
    raw_bit   = 1'b0;
    trng_req  = 1'b0;
    model_reset();
    #1;
    chk("init_empty", 32'(pool_empty), 32'd1);
    chk("init_hf", 32'(health_fail), 32'd0);
    chk("init_ur", 32'(underrun), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    check_all();

    // pairs (0,1)(1,0)(1,1)(0,0)(1,0) then three pops
    begin
      bit seq [10] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0};
      foreach (seq[i]) cyc(1'b1, seq[i], 1'b0);
    end
    chk("t1_count", 32'(pool_count), VN ? 32'd3 : 32'd10);
    for (int i = 0; i < 3; i++) begin
      chk("t1_bit", 32'(trng_bit), 32'(t1e[i]));
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("t1_left", 32'(pool_count), VN ? 32'd0 : 32'd7);
    chk("t1_ur", 32'(underrun), 32'd0);

    // underrun
    async_reset();
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_ur", 32'(underrun), 32'd1);
    chk("t4_bit", 32'(trng_bit), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("t4_ur_sticky", 32'(underrun), 32'd1);

    // full and drop
    async_reset();
    for (int i = 0; i < 33 * BPB; i++) cyc(1'b1, (i % 2) == 0, 1'b0);
    chk("t2_full", 32'(pool_count), 32'd32);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t2_drained", 32'(pool_count), 32'd0);

    // push/pop collision
    async_reset();
    for (int i = 0; i < 5 * BPB; i++) cyc(1'b1, (i % 2) == 0, 1'b0);
    chk("t3_start", 32'(pool_count), 32'd5);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, gen_rb(), 1'b1);
`ifndef TRNG_VN_DEBIAS_EN
      chk("t3_count", 32'(pool_count), 32'd5);
`endif
    end

    // health trip
    async_reset();
    for (int i = 0; i < 6 * BPB; i++) cyc(1'b1, (i % 2) == 0, 1'b0);
    chk("t5_start", 32'(pool_count), 32'd6);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t5_pre_hf", 32'(health_fail), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_hf", 32'(health_fail), 32'd1);
    chk("t5_count", 32'(pool_count), 32'd0);
    chk("t5_bit", 32'(trng_bit), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2) == 1, 1'b0);
    chk("t5_blocked", 32'(pool_count), 32'd0);

    // reset mid-operation with a half-formed pair
    async_reset();
    for (int i = 0; i < 10 * BPB; i++) cyc(1'b1, (i % 2) == 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    async_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t6_count", 32'(pool_count), VN ? 32'd1 : 32'd2);
    chk("t6_head", 32'(trng_bit), 32'd0);

    // random traffic, health test kept quiet
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 4)
        0:       reqp = 10;
        1:       reqp = 60;
        2:       reqp = 30;
        default: reqp = 90;
      endcase
      rv  = ($urandom_range(0, 3) != 0);
      rb  = gen_rb();
      req = ($urandom_range(0, 99) < reqp);
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc(rv, rb, req);
    end

    // random traffic with biased raw bits
    for (int i = 0; i < 600; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rb  = ($urandom_range(0, 9) < 8);
      req = ($urandom_range(0, 99) < 30);
      if (i % 100 == 99) async_reset();
      else cyc(rv, rb, req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
